// File: rtl/axis_width_converter_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream width-converter slave port among num_slaves requesters.
// Optional source tag output m_axis_tid is enabled by defining AXIS_ARB_TID_EN.
//
// state | meaning
// IDLE  | no grant held; pick next valid requester after last_idx
// GRANT | grant_idx owns the output stream for up to burst_beats beats
module axis_width_converter_arbiter #(
    parameter int bus_width   = 16,
    parameter int num_slaves  = 4,
    parameter int burst_beats = 16
) (
    input  logic                               aclk,
    input  logic                               arst,
    input  logic [num_slaves*bus_width*8-1:0]  s_axis_tdata,
    input  logic [num_slaves-1:0]              s_axis_tvalid,
    output logic [num_slaves-1:0]              s_axis_tready,
    output logic [bus_width*8-1:0]             m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready
`ifdef AXIS_ARB_TID_EN
    ,
    output logic [$clog2(num_slaves)-1:0]      m_axis_tid
`endif
);

    localparam int DW    = bus_width * 8;
    localparam int IDX_W = $clog2(num_slaves);
    localparam int CNT_W = $clog2(burst_beats) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(burst_beats - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             beat;

    // Rotating priority search: the most recently served port is checked last.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= num_slaves; k++) begin
            cand = (int'(last_idx_q) + k) % num_slaves;
            if (!pick_found && s_axis_tvalid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        last_idx_d    = last_idx_q;
        beat_cnt_d    = beat_cnt_q;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        beat          = 1'b0;
`ifdef AXIS_ARB_TID_EN
        m_axis_tid    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_d = pick_idx;
                    beat_cnt_d  = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                m_axis_tdata               = s_axis_tdata[int'(grant_idx_q) * DW +: DW];
                m_axis_tvalid              = s_axis_tvalid[grant_idx_q];
                s_axis_tready[grant_idx_q] = m_axis_tready;
`ifdef AXIS_ARB_TID_EN
                m_axis_tid                 = grant_idx_q;
`endif
                beat = m_axis_tvalid & m_axis_tready;
                // Release on an empty requester or on the final beat of the burst.
                if (!s_axis_tvalid[grant_idx_q] || (beat && beat_cnt_q == LAST_BEAT)) begin
                    last_idx_d = grant_idx_q;
                    state_d    = IDLE;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(num_slaves - 1);
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_width_converter_arbiter.sv
// Bench for axis_width_converter_arbiter: directed scenarios plus random traffic against an owner/beats-left model.
module tb_axis_width_converter_arbiter;

    localparam int N     = 4;
    localparam int BW    = 16;
    localparam int DW    = BW * 8;
    localparam int BURST = 16;

    logic            aclk = 1'b0;
    logic            arst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
`ifdef AXIS_ARB_TID_EN
    logic [$clog2(N)-1:0] m_tid;
`endif

    always #5 aclk = ~aclk;

    axis_width_converter_arbiter #(
        .bus_width  (BW),
        .num_slaves (N),
        .burst_beats(BURST)
    ) dut (
        .aclk         (aclk),
        .arst         (arst),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready)
`ifdef AXIS_ARB_TID_EN
        ,
        .m_axis_tid   (m_tid)
`endif
    );

    logic [DW-1:0] dat [N];
    int errors = 0;
    int checks = 0;

    // Reference: owner (-1 when nobody holds the stream), beats left in the burst, last served port.
    int holder = -1;
    int left   = 0;
    int last   = N - 1;

    bit            chk_on = 1'b0;
    int            hs_port;
    bit            rr_track = 1'b0;
    int            grants[$];
    logic [N-1:0]  prev_rdy = '0;
    logic          obs_v, obs_hs;
    logic [N-1:0]  obs_rdy;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = dat[i];
    endtask

    task automatic step();
        logic          ev;
        logic [DW-1:0] ed;
        logic [N-1:0]  er;
        @(negedge aclk);
        ev = (holder >= 0) ? s_tvalid[holder] : 1'b0;
        ed = (holder >= 0) ? dat[holder] : '0;
        er = '0;
        if (holder >= 0 && m_tready) er[holder] = 1'b1;
        if (chk_on) begin
            chk_eq("m_tvalid", DW'(m_tvalid), DW'(ev));
            chk_eq("m_tdata", m_tdata, ed);
            chk_eq("s_tready", DW'(s_tready), DW'(er));
`ifdef AXIS_ARB_TID_EN
            chk_eq("m_tid", DW'(m_tid), (holder >= 0) ? DW'(holder) : '0);
`endif
            if (prev_stall && m_tvalid) chk_eq("stall_stable", m_tdata, prev_data);
        end
        obs_v      = m_tvalid;
        obs_hs     = m_tvalid & m_tready;
        obs_rdy    = s_tready;
        prev_stall = m_tvalid & ~m_tready & ~arst;
        prev_data  = m_tdata;
        if (rr_track && s_tready != '0 && prev_rdy == '0)
            for (int i = 0; i < N; i++) if (s_tready[i]) grants.push_back(i);
        prev_rdy = s_tready;
        hs_port = (ev && m_tready && !arst) ? holder : -1;
        if (arst) begin
            holder = -1;
            last   = N - 1;
        end else if (holder < 0) begin
            for (int k = 1; k <= N; k++)
                if (holder < 0 && s_tvalid[(last + k) % N]) begin
                    holder = (last + k) % N;
                    left   = BURST;
                end
        end else if (!s_tvalid[holder]) begin
            last   = holder;
            holder = -1;
        end else if (m_tready) begin
            left--;
            if (left == 0) begin
                last   = holder;
                holder = -1;
            end
        end
        @(posedge aclk);
        #1;
        if (hs_port >= 0) begin
            dat[hs_port] = rnd_word();
            pack();
        end
    endtask

    task automatic do_reset(input int n);
        arst = 1'b1;
        repeat (n) step();
        arst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, n0, n3, hs_in_grant;
        int exp_rr[6] = '{0, 1, 3, 0, 1, 3};

        arst     = 1'b1;
        m_tready = 1'b0;
        s_tvalid = '1;
        for (int i = 0; i < N; i++) dat[i] = rnd_word();
        pack();

        // Reset held 4 cycles with every requester valid.
        step();
        chk_on = 1'b1;
        repeat (3) step();
        arst     = 1'b0;
        m_tready = 1'b1;
        step();
        chk_eq("rst_first_grant", DW'(s_tready), DW'(4'b0001));

        // Lone requester: 16 beats, one dead cycle, regrant.
        do_reset(2);
        s_tvalid = 4'b0100;
        step();
        cnt = 0;
        repeat (16) begin
            step();
            cnt += int'(obs_hs);
        end
        chk_eq("single_burst_beats", DW'(cnt), DW'(16));
        step();
        chk_eq("single_gap", DW'(obs_v), DW'(0));
        step();
        chk_eq("single_regrant", DW'(obs_rdy), DW'(4'b0100));

        // Round robin over ports 0, 1, 3.
        do_reset(2);
        s_tvalid = 4'b1011;
        grants.delete();
        prev_rdy = '0;
        rr_track = 1'b1;
        repeat (6 * 17 + 2) step();
        rr_track = 1'b0;
        chk_eq("rr_grant_count", DW'(grants.size() >= 6), DW'(1));
        if (grants.size() >= 6)
            for (int i = 0; i < 6; i++) chk_eq($sformatf("rr_order_%0d", i), DW'(grants[i]), DW'(exp_rr[i]));

        // Backpressure on port 1.
        do_reset(2);
        s_tvalid    = 4'b0010;
        hs_in_grant = 0;
        for (int c = 0; c < 140; c++) begin
            m_tready = 1'($urandom % 2);
            step();
            if (!obs_v) begin
                if (hs_in_grant > 0) chk_eq("bp_burst_len", DW'(hs_in_grant), DW'(16));
                hs_in_grant = 0;
            end else begin
                hs_in_grant += int'(obs_hs);
            end
        end

        // Early release of port 0 after 5 beats, port 1 waiting.
        do_reset(2);
        m_tready = 1'b1;
        s_tvalid = 4'b0011;
        n0 = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (hs_port == 0) n0++;
            if (n0 == 5) s_tvalid[0] = 1'b0;
        end
        chk_eq("early_beats_p0", DW'(n0), DW'(5));

        // Reset in the middle of a port-3 burst.
        do_reset(2);
        s_tvalid = 4'b1000;
        n3 = 0;
        for (int c = 0; c < 40 && n3 < 7; c++) begin
            step();
            if (hs_port == 3) n3++;
        end
        chk_eq("mid_beats_before_rst", DW'(n3), DW'(7));
        arst     = 1'b1;
        s_tvalid = '1;
        step();
        chk_eq("mid_rst_tvalid", DW'(m_tvalid), DW'(0));
        chk_eq("mid_rst_tdata", m_tdata, '0);
        chk_eq("mid_rst_tready", DW'(s_tready), DW'(0));
        arst = 1'b0;
        step();
        chk_eq("mid_rst_port0_first", DW'(s_tready), DW'(4'b0001));

        // Random traffic with occasional early release and reset.
        for (int c = 0; c < 2000; c++) begin
            m_tready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (!s_tvalid[i]) s_tvalid[i] = ($urandom % 4) == 0;
                else if ($urandom % 25 == 0) s_tvalid[i] = 1'b0;
            end
            arst = ($urandom % 400) == 0;
            step();
            if (hs_port >= 0 && $urandom % 3 == 0) s_tvalid[hs_port] = 1'b0;
        end
        arst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_width_converter_arbiter.md
Name: axis_width_converter_arbiter

Overview:
- Round-robin arbiter that shares one axis_data_width_converter slave port among several AXI-Stream requesters.
- Sits directly in front of the converter's s_axis interface.
- Grants one requester at a time for a bounded burst of beats, then rotates priority.
- Data path is a combinational mux with no added latency once a grant is held. Arbitration costs one cycle.

Parameters:
- bus_width, 16, byte width of every requester and of the output stream; data is bus_width*8 bits.
- num_slaves, 4, number of requester ports, 2..16.
- burst_beats, 16, maximum beats transferred per grant before forced rotation, 1..65535.

Ports:
- aclk  in  1  stream clock; all logic on the rising edge.
- arst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  num_slaves*bus_width*8  requester data; port i occupies bits [(i+1)*bus_width*8-1 : i*bus_width*8].
- s_axis_tvalid  in  num_slaves  per-requester valid.
- s_axis_tready  out  num_slaves  per-requester ready.
- m_axis_tdata  out  bus_width*8  muxed data to the converter s_axis_tdata.
- m_axis_tvalid  out  1  valid to the converter.
- m_axis_tready  in  1  ready from the converter.

Behaviour:
- Reset values (arst=1, takes effect at the next edge):
  - state=IDLE, grant_idx=0, last_idx=num_slaves-1, beat_cnt=0.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0.
- States: IDLE, GRANT.
- IDLE:
  - All s_axis_tready=0 and m_axis_tvalid=0.
  - If any s_axis_tvalid is high, pick the first set port searching from last_idx+1 upward, wrapping modulo num_slaves.
  - Load grant_idx with that port, clear beat_cnt, and go to GRANT on the next edge.
  - Latency from first tvalid to m_axis_tvalid is exactly 1 cycle.
- GRANT outputs:
  - m_axis_tdata = slice[grant_idx]; m_axis_tvalid = s_axis_tvalid[grant_idx].
  - s_axis_tready[grant_idx] = m_axis_tready; all other readies are 0.
  - Outputs are combinational in GRANT; m_axis_tdata is driven 0 in IDLE.
- A beat is counted when m_axis_tvalid & m_axis_tready.
- GRANT exits to IDLE and sets last_idx=grant_idx when either:
  - (a) a beat completes with beat_cnt==burst_beats-1, or
  - (b) s_axis_tvalid[grant_idx]==0 in GRANT, meaning the requester has nothing pending.
  - Otherwise beat_cnt increments on each beat.
- Rotation: the port just served has lowest priority in the next IDLE search.
  - A lone requester is re-granted after one IDLE cycle.
  - Every burst boundary costs exactly one dead cycle.
- AXIS rules:
  - m_axis_tvalid never drops without a handshake while s_axis_tvalid[grant_idx] holds, since the grant is never revoked mid-beat.
  - Data never changes source while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous events: when a beat completes on the last burst beat and other ports are also valid, exit is still to IDLE. The next port is chosen in IDLE, never in the same cycle.
- Reset mid-burst: state returns to IDLE, the beat is dropped, and the requester must re-present it. Priority restarts at port 0.
- beat_cnt width is clog2(burst_beats)+1. No wrap-around is possible because the count is bounded by burst_beats-1.

Optional Feature:
- Macro: AXIS_ARB_TID_EN.
- When defined:
  - Adds output m_axis_tid, width clog2(num_slaves), driven with grant_idx in GRANT and 0 in IDLE/reset.
  - Downstream logic can tag converted data with its source.
- When undefined: the port does not exist and no extra logic is generated.

Test Plan:
- Reset: hold arst 4 cycles with all s_axis_tvalid=1 -> all s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0. First release cycle is IDLE; port 0 is granted on the next cycle.
- Single requester: port 2 valid continuously, m_axis_tready=1, burst_beats=16 -> 16 beats pass through unmodified. Then exactly one cycle with m_axis_tvalid=0, then port 2 is regranted.
- Round-robin: ports 0, 1 and 3 valid continuously, m_axis_tready=1 -> grant order is 0,1,3,0,1,3, each with 16 beats. Port 2 is never granted.
- Backpressure: port 1 granted, m_axis_tready driven $random%2 as the converter does -> m_axis_tdata is stable while stalled. beat_cnt advances only on handshakes; exactly 16 handshakes per grant.
- Early release: port 0 drops tvalid after 5 beats while port 1 is valid -> GRANT exits, IDLE for 1 cycle, then port 1 is granted with beat_cnt=0.
- Reset mid-burst: assert arst after beat 7 of port 3 -> outputs are 0 next cycle. After release, port 0 is searched first.
